uart_rx_depacketizer: RTL and testbench
=======================================

// Module: uart_rx_depacketizer
// PURPOSE
//  UART receive side of the packet link: samples serial_in, deframes 8N1 characters
//  (8E1 with UART_PARITY_EN) and pushes each good byte into the RX FIFO via a write strobe.
//  Sits between the board RX pin and the RX FIFO; mirror of the TX packetizer.
//  Flags framing, overrun and (optional) parity errors as single-cycle pulses.
// PARAMETERS
//  CLK_FREQ    50000000            system clock frequency, Hz
//  BAUD_RATE   115200              line rate, bit/s
//  DATA_WIDTH  8                   data bits per character, LSB first
//  BAUD_COUNT  CLK_FREQ/BAUD_RATE  clocks per bit (434 at defaults); must be >= 4
// PORTS
//  clk            in   1           system clock, all logic on rising edge
//  rst_n          in   1           asynchronous, active-low reset
//  serial_in      in   1           asynchronous UART line, idle high
//  fifo_full      in   1           RX FIFO cannot accept a write this cycle
//  fifo_write_en  out  1           one-cycle write strobe to RX FIFO
//  fifo_wr_data   out  DATA_WIDTH  received byte, valid while fifo_write_en=1
//  rx_busy        out  1           1 from start-edge detect until return to IDLE
//  frame_err      out  1           one-cycle pulse: stop bit sampled 0
//  overrun_err    out  1           one-cycle pulse: good byte dropped, fifo_full=1
//  parity_err     out  1           one-cycle pulse: parity mismatch (tied 0 without macro)
//  debug_state    out  3           registered copy of current state
// BEHAVIOUR
//  Reset: state=IDLE, all strobes/errors 0, fifo_wr_data=0, rx_busy=0, debug_state=0,
//   synchroniser flops=1. Reset mid-character aborts it; no write, no error pulse.
//  serial_in passes a 2-flop synchroniser; all decisions use the synced value (rxs).
//  States (3'd): IDLE=0 START=1 DATA=2 PARITY=3 STOP=4 WRITE=5.
//  IDLE: on rxs 1->0 edge go START, clear baud counter. A line held low never retriggers.
//  START: wait BAUD_COUNT/2 clocks (mid-bit); rxs=0 -> DATA, counter cleared;
//   rxs=1 -> glitch, back to IDLE, no pulse.
//  DATA: sample rxs every BAUD_COUNT clocks, shift right into shift_reg (MSB in);
//   after DATA_WIDTH samples -> PARITY (macro) or STOP.
//  STOP: sample after BAUD_COUNT clocks. rxs=0 -> frame_err=1 one cycle, byte dropped, IDLE.
//   rxs=1 -> WRITE.
//  WRITE (1 cycle): fifo_full=0 -> fifo_write_en=1, fifo_wr_data=shift_reg;
//   fifo_full=1 -> overrun_err=1, no write. Always -> IDLE next cycle.
//  Latency: fifo_write_en rises 1 clk after the mid-stop-bit sample, ~9.5 bit times after start edge.
//  Parity and framing errors both present: frame_err only; byte dropped.
//  Counter is BAUD_COUNT-wide ($clog2), wraps to 0 at BAUD_COUNT-1; never free-runs in IDLE.
// CONFIGURATION
//  UART_PARITY_EN defined: PARITY state samples one even-parity bit after data;
//   mismatch latched, reported as parity_err pulse in WRITE cycle, byte not written.
//  Undefined: PARITY state unreachable, DATA -> STOP directly, parity_err tied 0.
// STRUCTURE
//  Package uart_pkg: state encodings (shared with TX packetizer), default CLK_FREQ/BAUD_RATE,
//   BAUD_COUNT function, DATA_WIDTH default.
//  Sub-module uart_rx_sync: 2-flop synchroniser + falling-edge detect (rst_n sets to 1).
//  Top holds FSM, baud counter, bit counter, shift register, output registers.
// TESTING (BAUD_COUNT=16 in bench for speed)
//  1 Send 0xA5 8N1, fifo_full=0 -> single fifo_write_en, fifo_wr_data=0xA5, no errors.
//  2 Back-to-back 0x00,0xFF,0x55 with 1-bit idle gaps -> three writes in order, values exact.
//  3 Low glitch of 4 clks on idle line -> returns IDLE, no write, rx_busy pulse <=8 clks.
//  4 0x3C with stop bit forced 0 -> frame_err one cycle, no write; next 0x12 received clean.
//  5 0x81 with fifo_full=1 -> overrun_err one cycle, no write; rx_busy clears.
//  6 rst_n low mid DATA of 0x77 -> all outputs reset values; next 0x42 received correctly;
//    with UART_PARITY_EN, 0x42 with wrong parity -> parity_err, no write.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART RX depacketizer and TX packetizer.
// State encodings are fixed 3-bit values so debug_state decodes the same on
// both sides of the link.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ   = 50000000;
    localparam int unsigned DEF_BAUD_RATE  = 115200;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;
    localparam uart_state_t ST_WRITE  = 3'd5;

    // Clocks per bit period.
    function automatic int unsigned baud_count(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous UART line plus a
// falling-edge detect on the synchronised value. All flops reset to 1 (idle
// line level) so reset release never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic serial_in,
    output logic rxs,
    output logic rx_fall
);

    logic meta;
    logic rxs_d;

    // Synchroniser chain and one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            meta  <= serial_in;
            rxs   <= meta;
            rxs_d <= rxs;
        end
    end

    assign rx_fall = rxs_d & ~rxs;

endmodule

// File: rtl/uart_rx_depacketizer.sv
// uart_rx_depacketizer: UART receiver feeding the RX FIFO.
// Deframes 8N1 characters (8E1 when UART_PARITY_EN is defined), samples each
// bit at mid-period, and writes good bytes to the FIFO with a one-cycle strobe.
// Framing, overrun and parity errors are reported as one-cycle pulses.
// Optional feature macro: UART_PARITY_EN (even parity bit after data).
module uart_rx_depacketizer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BAUD_COUNT = baud_count(CLK_FREQ, BAUD_RATE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  serial_in,
    input  logic                  fifo_full,
    output logic                  fifo_write_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  rx_busy,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  parity_err,
    output logic [2:0]            debug_state
);

    localparam int unsigned CW = $clog2(BAUD_COUNT);
    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_COUNT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_COUNT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    logic                  rxs;
    logic                  rx_fall;
    uart_state_t           state;
    logic [CW-1:0]         baud_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
`ifdef UART_PARITY_EN
    logic                  parity_bad;
    logic                  parity_err_q;
`endif

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .serial_in (serial_in),
        .rxs       (rxs),
        .rx_fall   (rx_fall)
    );

    // Receive FSM with baud/bit counters, shift register and output pulses.
    // rx_busy is updated alongside every state change so it equals (state != IDLE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            fifo_write_en <= 1'b0;
            fifo_wr_data  <= '0;
            rx_busy       <= 1'b0;
            frame_err     <= 1'b0;
            overrun_err   <= 1'b0;
`ifdef UART_PARITY_EN
            parity_bad    <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            fifo_write_en <= 1'b0;
            frame_err     <= 1'b0;
            overrun_err   <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (rx_fall) begin
                        state   <= ST_START;
                        rx_busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_cnt == CNT_HALF) begin
                        baud_cnt <= '0;
                        if (!rxs) begin
                            state <= ST_DATA;
                        end else begin
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rxs, shift_reg[DATA_WIDTH-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_PARITY_EN
                            state   <= ST_PARITY;
`else
                            state   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt   <= '0;
                        parity_bad <= rxs ^ (^shift_reg);
                        state      <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                            rx_busy   <= 1'b0;
                        end else begin
                            state <= ST_WRITE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    state   <= ST_IDLE;
                    rx_busy <= 1'b0;
`ifdef UART_PARITY_EN
                    if (parity_bad) begin
                        parity_err_q <= 1'b1;
                    end else
`endif
                    if (fifo_full) begin
                        overrun_err <= 1'b1;
                    end else begin
                        fifo_write_en <= 1'b1;
                        fifo_wr_data  <= shift_reg;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    // Registered copy of the FSM state for observation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            debug_state <= '0;
        end else begin
            debug_state <= state;
        end
    end

`ifdef UART_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_depacketizer.sv
// Testbench for uart_rx_depacketizer at BAUD_COUNT=16. Stimulus pushes the
// expected FIFO writes and error pulses into a scoreboard queue; a monitor on
// the falling clock edge pops and compares each event the DUT presents.
module tb_uart_rx_depacketizer;

    localparam int unsigned BC = 16;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {EV_WR, EV_FRAME, EV_OVR, EV_PAR} ev_kind_t;
    typedef struct packed {
        ev_kind_t      kind;
        logic [DW-1:0] data;
    } ev_t;

    logic          clk;
    logic          rst_n;
    logic          serial_in;
    logic          fifo_full;
    logic          fifo_write_en;
    logic [DW-1:0] fifo_wr_data;
    logic          rx_busy;
    logic          frame_err;
    logic          overrun_err;
    logic          parity_err;
    logic [2:0]    debug_state;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;

    uart_rx_depacketizer #(
        .CLK_FREQ   (1600),
        .BAUD_RATE  (100),
        .DATA_WIDTH (DW),
        .BAUD_COUNT (BC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .serial_in     (serial_in),
        .fifo_full     (fifo_full),
        .fifo_write_en (fifo_write_en),
        .fifo_wr_data  (fifo_wr_data),
        .rx_busy       (rx_busy),
        .frame_err     (frame_err),
        .overrun_err   (overrun_err),
        .parity_err    (parity_err),
        .debug_state   (debug_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [DW-1:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k, input logic [DW-1:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected none", k, d);
        end else begin
            e = sb.pop_front();
            chk("event_kind", int'(k), int'(e.kind));
            if (k == EV_WR && e.kind == EV_WR)
                chk("write_data", int'(d), int'(e.data));
        end
    endtask

    // Monitor: every strobe/pulse seen on the falling edge must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_write_en) observe(EV_WR, fifo_wr_data);
            if (frame_err)     observe(EV_FRAME, '0);
            if (overrun_err)   observe(EV_OVR, '0);
            if (parity_err)    observe(EV_PAR, '0);
        end
    end

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (BC) @(negedge clk);
    endtask

    // One character: start, data LSB first, [parity], stop, then one idle bit.
    task automatic send_byte(input logic [DW-1:0] d, input logic stop_bit,
                             input logic bad_parity);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit((^d) ^ bad_parity);
`else
        if (bad_parity) drive_bit(1'b1);
`endif
        drive_bit(stop_bit);
        drive_bit(1'b1);
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || rx_busy) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_write_en"}, int'(fifo_write_en), 0);
        chk({tag, "_wr_data"},  int'(fifo_wr_data), 0);
        chk({tag, "_busy"},     int'(rx_busy), 0);
        chk({tag, "_frame"},    int'(frame_err), 0);
        chk({tag, "_overrun"},  int'(overrun_err), 0);
        chk({tag, "_parity"},   int'(parity_err), 0);
        chk({tag, "_state"},    int'(debug_state), 0);
    endtask

    initial begin
        int busy_cyc;
        int max_state;
        serial_in = 1'b1;
        fifo_full = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", int'(rx_busy), 0);

        // 1: single clean byte
        expect_ev(EV_WR, 8'hA5);
        send_byte(8'hA5, 1'b1, 1'b0);
        wait_drain("t1_drain");

        // 2: back-to-back bytes with one idle bit between them
        expect_ev(EV_WR, 8'h00);
        expect_ev(EV_WR, 8'hFF);
        expect_ev(EV_WR, 8'h55);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        wait_drain("t2_drain");
        chk("t2_last_data", int'(fifo_wr_data), 8'h55);

        // 3: 4-clock low glitch must be rejected at the mid-start sample
        serial_in = 1'b0;
        repeat (4) @(negedge clk);
        serial_in = 1'b1;
        busy_cyc  = 0;
        max_state = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_busy) busy_cyc++;
            if (int'(debug_state) > max_state) max_state = int'(debug_state);
        end
        chk("t3_busy_seen", int'(busy_cyc > 0), 1);
        chk("t3_busy_le8", int'(busy_cyc <= 8), 1);
        chk("t3_max_state", max_state, 1);
        chk("t3_busy_end", int'(rx_busy), 0);

        // 4: stop bit low -> frame error only; next byte clean
        expect_ev(EV_FRAME, '0);
        send_byte(8'h3C, 1'b0, 1'b0);
        drive_bit(1'b1);
        wait_drain("t4_frame_drain");
        expect_ev(EV_WR, 8'h12);
        send_byte(8'h12, 1'b1, 1'b0);
        wait_drain("t4_clean_drain");

        // 5: FIFO full -> overrun, no write
        fifo_full = 1'b1;
        expect_ev(EV_OVR, '0);
        send_byte(8'h81, 1'b1, 1'b0);
        wait_drain("t5_drain");
        chk("t5_busy_clear", int'(rx_busy), 0);
        fifo_full = 1'b0;

        // 6: reset in the middle of the data bits of 0x77
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("t6_state_data", int'(debug_state), 2);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_reset");
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BC) @(negedge clk);
        chk("t6_idle_after", int'(rx_busy), 0);
        expect_ev(EV_WR, 8'h42);
        send_byte(8'h42, 1'b1, 1'b0);
        wait_drain("t6_drain");
`ifdef UART_PARITY_EN
        expect_ev(EV_PAR, '0);
        send_byte(8'h42, 1'b1, 1'b1);
        wait_drain("t6_parity_drain");
`endif

        repeat (BC) @(negedge clk);
        chk("final_queue_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
